// File: rtl/ifft8_seq.sv
// ifft8_seq: sequential 8-point radix-2 DIT inverse FFT, one shared butterfly, 1/8 scaling
module ifft8_seq #(
  parameter int DW = 16,
  parameter int TW_C = 23170
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_imag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_real,
  output logic signed [DW-1:0] out_imag,
  output logic                 out_last,
  output logic                 busy
);
  localparam logic [1:0] S_LOAD = 2'd0, S_COMP = 2'd1, S_UNLD = 2'd2;
  localparam logic signed [DW+2:0] TWC = (DW+3)'(TW_C);
  localparam logic signed [DW+2:0] MAXV = {4'b0000, {(DW-1){1'b1}}};
  localparam logic signed [DW+2:0] MINV = {4'b1111, {(DW-1){1'b0}}};

  logic [1:0] state_q, state_d;
  logic [2:0] ld_q, ld_d, oi_q, oi_d;
  logic [3:0] bf_q, bf_d;
  logic signed [DW-1:0] re_q [8];
  logic signed [DW-1:0] im_q [8];
  logic in_hs, out_hs;
  logic [1:0] s, b, pos, k;
  logic [2:0] bx, half, top, bot;
  logic signed [DW+2:0] arx, aix, brx, bix, sum_w, dif_w, cs, cd, tr, ti, pr, pi_w, mr, mi;
  logic signed [2*DW+5:0] ps, pd;
  logic signed [DW-1:0] nr_t, ni_t, nr_b, ni_b;

  function automatic logic signed [DW-1:0] sat(input logic signed [DW+2:0] x);
    logic signed [DW+2:0] y;
    y = x >>> 1;
    return (y > MAXV) ? {1'b0, {(DW-1){1'b1}}} : (y < MINV) ? {1'b1, {(DW-1){1'b0}}} : y[DW-1:0];
  endfunction

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_UNLD);
  assign busy      = !in_ready;
  assign out_last  = out_valid && (oi_q == 3'd7);
  assign out_real  = re_q[oi_q];
  assign out_imag  = im_q[oi_q];
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  // butterfly b of stage s: pairs top/top+half, twiddle exponent k
  always_comb begin
    s    = bf_q[3:2];
    b    = bf_q[1:0];
    bx   = {1'b0, b};
    half = 3'd1 << s;
    pos  = b & half[1:0] - 2'd1;
    top  = ((bx >> s) << (s + 2'd1)) | {1'b0, pos};
    bot  = top | half;
    k    = pos << (2'd2 - s);
    arx  = re_q[top];
    aix  = im_q[top];
    brx  = re_q[bot];
    bix  = im_q[bot];
    sum_w = brx + bix;
    dif_w = brx - bix;
    ps   = sum_w * TWC;
    pd   = dif_w * TWC;
    cs   = (DW+3)'(ps >>> 15);
    cd   = (DW+3)'(pd >>> 15);
    tr   = (k == 2'd0) ? brx : (k == 2'd2) ? -bix : (k == 2'd1) ? cd : -cs;
    ti   = (k == 2'd0) ? bix : (k == 2'd2) ? brx : (k == 2'd1) ? cs : cd;
    pr   = arx + tr;
    pi_w = aix + ti;
    mr   = arx - tr;
    mi   = aix - ti;
    nr_t = sat(pr);
    ni_t = sat(pi_w);
    nr_b = sat(mr);
    ni_b = sat(mi);
  end

  always_comb begin
    ld_d    = in_hs ? ld_q + 3'd1 : ld_q;
    oi_d    = out_hs ? oi_q + 3'd1 : oi_q;
    bf_d    = (state_q == S_COMP) ? ((bf_q == 4'd11) ? 4'd0 : bf_q + 4'd1) : bf_q;
    state_d = (in_hs && ld_q == 3'd7) ? S_COMP :
              (state_q == S_COMP && bf_q == 4'd11) ? S_UNLD :
              (out_hs && oi_q == 3'd7) ? S_LOAD : state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      ld_q    <= '0;
      bf_q    <= '0;
      oi_q    <= '0;
      for (int i = 0; i < 8; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      bf_q    <= bf_d;
      oi_q    <= oi_d;
      if (in_hs) begin
        re_q[{ld_q[0], ld_q[1], ld_q[2]}] <= in_real;
        im_q[{ld_q[0], ld_q[1], ld_q[2]}] <= in_imag;
      end
      if (state_q == S_COMP) begin
        re_q[top] <= nr_t;
        im_q[top] <= ni_t;
        re_q[bot] <= nr_b;
        im_q[bot] <= ni_b;
      end
    end
  end
endmodule

// File: tb/tb_ifft8_seq.sv
// tb_ifft8_seq: directed frames with scoreboard queue and decoupled output monitor
module tb_ifft8_seq;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic signed [15:0] in_real, in_imag, out_real, out_imag;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic last;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  bit bp = 1'b0;
  bit held = 1'b0;
  logic signed [15:0] h_re, h_im;
  int bre[8], bim[8], ere[8], eim[8];
  int tone_re[8] = '{1024, 724, 0, -724, -1024, -724, 0, 724};
  int tone_im[8] = '{0, 724, 1024, 724, 0, -724, -1024, -724};

  ifft8_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) held = 1'b0;
      else begin
        check("ready_vs_busy", int'(in_ready), int'(!busy));
        if (held) begin
          check("hold_re", out_real, h_re);
          check("hold_im", out_imag, h_im);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) check("spurious_output", 1, 0);
          else begin
            e = sb.pop_front();
            check("out_re", out_real, $signed(e.re));
            check("out_im", out_imag, $signed(e.im));
            check("out_last", int'(out_last), int'(e.last));
          end
        end
        held = out_valid && !out_ready;
        h_re = out_real;
        h_im = out_imag;
      end
    end
  endtask

  task automatic rdy();
    bit [3:0] pat = 4'b1001;
    int cyc = 0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = bp ? pat[cyc % 4] : 1'b1;
      cyc++;
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 8; i++) begin
      bre[i] = 0; bim[i] = 0; ere[i] = 0; eim[i] = 0;
    end
  endtask

  task automatic impulse();
    clr();
    bre[0] = 8192;
    for (int i = 0; i < 8; i++) ere[i] = 1024;
  endtask

  task automatic run_frame(input bit gap, input bit junk, input bit lat);
    int t = 0;
    int n = 0;
    for (int i = 0; i < 8; i++) sb.push_back('{re: 16'(ere[i]), im: 16'(eim[i]), last: (i == 7)});
    @(posedge clk);
    #2;
    while (!in_ready && t < 100) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("frame_start_ready", int'(in_ready), 1);
    for (int i = 0; i < 8; i++) begin
      if (gap && i[0]) begin
        in_valid = 1'b0;
        @(posedge clk);
        #2;
      end
      in_valid = 1'b1;
      in_real = 16'(bre[i]);
      in_imag = 16'(bim[i]);
      @(posedge clk);
      #2;
    end
    in_valid = junk;
    in_real = 16'sh7abc;
    in_imag = -16'sd1234;
    if (lat) begin
      do begin
        @(posedge clk);
        #2;
        n++;
        if (n == 10) in_valid = 1'b0;
      end while (!out_valid && n < 40);
      check("latency", n, 12);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic reset_now();
    rst = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_real", out_real, 0);
    check("rst_out_imag", out_imag, 0);
    sb.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int t;
    rst = 1'b1;
    in_valid = 1'b0;
    in_real = '0;
    in_imag = '0;
    out_ready = 1'b1;
    fork
      mon();
      rdy();
    join_none
    #12;
    reset_now();
    impulse();
    run_frame(0, 0, 1);
    drain();
    clr();
    bre[0] = 8000;
    for (int i = 0; i < 8; i++) ere[i] = 1000;
    run_frame(0, 0, 1);
    drain();
    clr();
    for (int i = 0; i < 8; i++) bre[i] = 8000;
    ere[0] = 8000;
    run_frame(0, 0, 1);
    drain();
    clr();
    bre[1] = 8192;
    for (int i = 0; i < 8; i++) begin
      ere[i] = tone_re[i];
      eim[i] = tone_im[i];
    end
    run_frame(0, 0, 1);
    drain();
    bp = 1'b1;
    run_frame(1, 1, 1);
    drain();
    bp = 1'b0;
    clr();
    for (int i = 0; i < 8; i++) begin
      bre[i] = 32767;
      bim[i] = 32767;
    end
    ere[0] = 32767;
    eim[0] = 32767;
    run_frame(0, 0, 1);
    drain();
    impulse();
    run_frame(0, 0, 0);
    repeat (4) @(posedge clk);
    #2;
    check("mid_compute_busy", int'(busy), 1);
    reset_now();
    run_frame(0, 0, 1);
    drain();
    run_frame(0, 0, 1);
    t = 0;
    while (sb.size() > 5 && t < 200) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("mid_unload_reached", sb.size(), 5);
    reset_now();
    run_frame(0, 0, 1);
    drain();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ifft8_seq.md
Name: ifft8_seq

Overview:
- Sequential 8-point radix-2 decimation-in-time inverse FFT engine.
- Sits downstream of the forward FFT datapath; converts frequency-domain bins back to time-domain samples.
- Accepts 8 complex bins serially over a valid/ready stream and computes in place with one shared butterfly (3 stages x 4 butterflies).
- Streams 8 time samples out in natural order, scaled by 1/8.

Parameters:
- DW, 16, signed two's-complement width of each real/imag component.
- TW_C, 23170, cos(pi/4) in Q1.15, used for the odd stage-2 twiddles.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input bin valid.
- in_ready  out  1  engine can accept a bin.
- in_real  in  DW  input bin real part.
- in_imag  in  DW  input bin imaginary part.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_real  out  DW  output sample real part.
- out_imag  out  DW  output sample imaginary part.
- out_last  out  1  high with the 8th output sample (index 7).
- busy  out  1  high in COMPUTE or UNLOAD.

Behaviour:
- Storage: 8-entry complex register file. States: LOAD, COMPUTE, UNLOAD.
- Reset (async, any state, mid-frame included):
  - state=LOAD; load, butterfly and output counters = 0; register file cleared.
  - in_ready=1; out_valid=0, out_last=0, busy=0, out_real=0, out_imag=0.
  - Partial frames are discarded.
- LOAD:
  - in_ready=1. On each handshake (in_valid & in_ready), bin n (n=0..7, arrival order) is written to address bitrev3(n).
  - The handshake of bin 7 moves the state to COMPUTE at that edge.
  - in_valid low stalls the counter. Inputs are ignored while in_ready=0.
- COMPUTE: exactly 12 cycles, one butterfly per cycle, stage s=0..2, butterfly b=0..3.
  - Addressing: half=1<<s; pos=b&(half-1); top=(b>>s)*2*half+pos; bot=top+half; twiddle index k=pos<<(2-s).
  - Inverse twiddles W8^-k (multiply b by):
    - k=0: 1.
    - k=2: +j, i.e. (-bi, br).
    - k=1: ((br-bi)*C, (br+bi)*C).
    - k=3: (-(br+bi)*C, (br-bi)*C).
    - Here X*C = (X*TW_C)>>>15, where X is the 17-bit sum/difference.
  - Butterfly:
    - t = W*b in 18-bit signed.
    - top' = sat16((a+t)>>>1); bot' = sat16((a-t)>>>1).
    - >>> is arithmetic shift (floor). sat16 clamps to [-32768, 32767].
  - Both results are written back in the same cycle.
  - After the 12th butterfly the state is UNLOAD. in_ready=0 and out_valid=0 throughout COMPUTE.
- UNLOAD:
  - out_valid=1; out_real/out_imag = register file[out_idx], driven from registers.
  - out_last = (out_idx==7).
  - On each handshake out_idx increments. out_ready low holds data stable; the output must not change while out_valid & !out_ready.
  - The handshake at out_idx 7 returns to LOAD with counters = 0; in_ready rises the next cycle (no overlap between frames).
- Latency: out_valid rises 12 edges after the edge carrying the 8th input handshake. Minimum frame period is 8+12+8 = 28 cycles.
- Overall scaling: 1/8 (one halving per stage), matching the mathematical IFFT.

Test Plan:
- Impulse: bin0=(8192,0), others 0, out_ready=1 -> all 8 outputs (1024,0); out_last only on the 8th; out_valid first high exactly 12 cycles after the 8th input handshake.
- DC bin only: all bins 0 except bin0=(8000,0) -> outputs all (1000,0). Next, all bins (8000,0) -> output0=(8000,0), outputs 1..7=(0,0).
- Single tone: bin1=(8192,0), others 0 -> output n = 1024*(cos(2*pi*n/8), sin(2*pi*n/8)) within +/-1 LSB. Output 0=(1024,0), output 2=(0,1024), output 4=(-1024,0), output 1 ~ (724,724).
- Backpressure: tone case with out_ready toggled 1,0,0,1,... and in_valid gaps during LOAD -> identical sample sequence; data held stable while stalled; in_ready=0 during COMPUTE/UNLOAD and inputs presented then are ignored.
- Saturation: all bins (32767,32767) -> no wrap; output0 = (32767,32767) clamped or exact per the rules, and no output changes sign unexpectedly.
- Reset mid-COMPUTE and mid-UNLOAD: assert rst -> outputs 0, in_ready=1 immediately (async). A following impulse frame produces the correct all-(1024,0) result.
